// File: rtl/vscale_htif_pcr_arbiter_if.sv
// Requester-side and CSR-side HTIF PCR signals of the arbiter.
// slave = arbiter view, master = environment (requesters + CSR file) view.
interface vscale_htif_pcr_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        resp_valid;
  logic [N_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]       resp_data;

  logic                    pcr_req_valid;
  logic                    pcr_req_ready;
  logic                    pcr_req_rw;
  logic [ADDR_W-1:0]       pcr_req_addr;
  logic [DATA_W-1:0]       pcr_req_data;
  logic                    pcr_resp_valid;
  logic                    pcr_resp_ready;
  logic [DATA_W-1:0]       pcr_resp_data;

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, resp_ready,
           pcr_req_ready, pcr_resp_valid, pcr_resp_data,
    output req_ready, resp_valid, resp_data,
           pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready
  );

  modport master (
    output req_valid, req_rw, req_addr, req_data, resp_ready,
           pcr_req_ready, pcr_resp_valid, pcr_resp_data,
    input  req_ready, resp_valid, resp_data,
           pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready
  );
endinterface

// File: rtl/vscale_htif_pcr_arbiter.sv
// N_REQ-way arbiter for the vscale HTIF PCR channel, one transaction in flight.
// Define VSCALE_HTIF_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module vscale_htif_pcr_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  vscale_htif_pcr_arbiter_if.slave      bus,
  output logic                          busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               resp_done;

  assign resp_done = (state == S_WAIT) && bus.pcr_resp_valid && bus.resp_ready[grant];

`ifdef VSCALE_HTIF_ARB_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'(k);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % 32'(N_REQ));
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (resp_done) begin
      rr_ptr <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= '0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && found) begin
        grant  <= winner;
        rw_q   <= bus.req_rw[winner];
        addr_q <= bus.req_addr[int'(winner) * ADDR_W +: ADDR_W];
        data_q <= bus.req_data[int'(winner) * DATA_W +: DATA_W];
      end
    end
  end

  // IDLE keeps pcr_resp_ready high so stale responses are drained, never routed.
  always_comb begin
    state_next         = state;
    bus.req_ready      = '0;
    bus.resp_valid     = '0;
    bus.resp_data      = '0;
    bus.pcr_resp_ready = 1'b0;
    case (state)
      S_IDLE: begin
        bus.pcr_resp_ready = 1'b1;
        if (found) begin
          bus.req_ready[winner] = 1'b1;
          state_next            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.pcr_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        bus.resp_valid[grant] = bus.pcr_resp_valid;
        bus.resp_data         = bus.pcr_resp_data;
        bus.pcr_resp_ready    = bus.resp_ready[grant];
        if (resp_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.pcr_req_valid = (state == S_ISSUE);
  assign bus.pcr_req_rw    = rw_q;
  assign bus.pcr_req_addr  = addr_q;
  assign bus.pcr_req_data  = data_q;
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Scoreboard bench for vscale_htif_pcr_arbiter: a 2-requester instance with a
// behavioural CSR responder and a 3-requester instance for pointer wrap.
module tb_vscale_htif_pcr_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy2, busy3;
  int   n_vec = 0;
  int   n_miss = 0;

  bit   ds_en = 1'b1;
  int   ds_stall = 0;
  logic req_hs, resp_hs, stalling, c_rw;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   grant_q[$];

  vscale_htif_pcr_arbiter_if #(.N_REQ(2), .ADDR_W(AW), .DATA_W(DW)) bus2 ();
  vscale_htif_pcr_arbiter_if #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  vscale_htif_pcr_arbiter #(.N_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .busy(busy2));
  vscale_htif_pcr_arbiter #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .busy(busy3));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ds_model(input logic rw, input logic [AW-1:0] a,
                                             input logic [DW-1:0] wd);
    if (a == 12'h780) return 64'h0000_0000_DEAD_BEEF;
    return {52'h5_A5A5_A5A5_A5A5, a} ^ (rw ? wd : 64'h0);
  endfunction

  // CSR-file responder for bus2: optional request stall, response one cycle after acceptance.
  initial begin
    bus2.pcr_req_ready  = 1'b1;
    bus2.pcr_resp_valid = 1'b0;
    bus2.pcr_resp_data  = '0;
    forever begin
      @(negedge clk);
      req_hs   = bus2.pcr_req_valid && bus2.pcr_req_ready;
      resp_hs  = bus2.pcr_resp_valid && bus2.pcr_resp_ready;
      stalling = bus2.pcr_req_valid && !bus2.pcr_req_ready;
      c_rw = bus2.pcr_req_rw; c_addr = bus2.pcr_req_addr; c_data = bus2.pcr_req_data;
      @(posedge clk); #1;
      if (ds_en) begin
        if (resp_hs) bus2.pcr_resp_valid = 1'b0;
        if (stalling && ds_stall > 0) ds_stall--;
        if (req_hs) begin
          bus2.pcr_resp_valid = 1'b1;
          bus2.pcr_resp_data  = ds_model(c_rw, c_addr, c_data);
        end
        bus2.pcr_req_ready = (ds_stall == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input int i, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bus2.req_valid[i] = 1'b1;
    bus2.req_rw[i] = rw;
    bus2.req_addr[i*AW +: AW] = a;
    bus2.req_data[i*DW +: DW] = d;
  endtask

  // Waits (from a check point) until bus2 shows any resp_valid; reports cycles waited.
  task automatic wait_resp(input int lim, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int c = 0; c < lim; c++) begin
      if (bus2.resp_valid != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick(); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); #1;
    n_vec++;
    if ({bus2.req_ready, bus2.resp_valid, bus2.pcr_req_valid, busy2} !== 6'b0) begin
      n_miss++;
      $display("FAIL reset_outputs2: got %b want %b",
               {bus2.req_ready, bus2.resp_valid, bus2.pcr_req_valid, busy2}, 6'b0);
    end
    n_vec++;
    if (bus2.resp_data !== 64'h0 || bus2.pcr_resp_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_data_ready: got %h/%b want 0/1", bus2.resp_data, bus2.pcr_resp_ready);
    end
    n_vec++;
    if ({bus3.req_ready, bus3.resp_valid, bus3.pcr_req_valid, busy3} !== 8'b0) begin
      n_miss++;
      $display("FAIL reset_outputs3: got %b want %b",
               {bus3.req_ready, bus3.resp_valid, bus3.pcr_req_valid, busy3}, 8'b0);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bit ok; int cyc; exp_t e;
    exp_q.push_back('{1, 64'h0000_0000_DEAD_BEEF});
    drive_req(1, 1'b0, 12'h780, 64'h0); #1;
    n_vec++;
    if (bus2.req_ready !== 2'b10) begin
      n_miss++; $display("FAIL read_grant: got %b want 10", bus2.req_ready);
    end
    tick(); bus2.req_valid = '0; #1;
    n_vec++;
    if ({bus2.req_ready, bus2.pcr_req_valid, bus2.pcr_req_rw, bus2.pcr_req_addr} !== {2'b00, 1'b1, 1'b0, 12'h780}) begin
      n_miss++;
      $display("FAIL read_issue: got %h want %h",
               {bus2.req_ready, bus2.pcr_req_valid, bus2.pcr_req_rw, bus2.pcr_req_addr}, {2'b00, 1'b1, 1'b0, 12'h780});
    end
    wait_resp(10, ok, cyc);
    n_vec++;
    if (!ok || cyc != 1) begin
      n_miss++; $display("FAIL read_latency: got ok=%0d cyc=%0d want ok=1 cyc=1", ok, cyc);
    end
    if (ok) begin
      e = exp_q.pop_front();
      n_vec++;
      if (bus2.resp_valid !== 2'(1 << e.idx) || bus2.resp_data !== e.data) begin
        n_miss++;
        $display("FAIL read_resp: got %b/%h want %b/%h", bus2.resp_valid, bus2.resp_data, 2'(1 << e.idx), e.data);
      end
    end
    tick(); #1;
    n_vec++;
    if ({bus2.resp_valid, busy2} !== 3'b000) begin
      n_miss++; $display("FAIL read_done: got %b want 000", {bus2.resp_valid, busy2});
    end
    tick();
  endtask

  task automatic test_write();
    bit ok; int cyc; exp_t e;
    exp_q.push_back('{0, ds_model(1'b1, 12'h781, 64'h1234)});
    drive_req(0, 1'b1, 12'h781, 64'h1234); #1;
    n_vec++;
    if (bus2.req_ready !== 2'b01) begin
      n_miss++; $display("FAIL write_grant: got %b want 01", bus2.req_ready);
    end
    tick(); bus2.req_valid = '0; #1;
    n_vec++;
    if ({bus2.pcr_req_rw, bus2.pcr_req_addr, bus2.pcr_req_data} !== {1'b1, 12'h781, 64'h1234}) begin
      n_miss++;
      $display("FAIL write_issue: got %h want %h",
               {bus2.pcr_req_rw, bus2.pcr_req_addr, bus2.pcr_req_data}, {1'b1, 12'h781, 64'h1234});
    end
    wait_resp(10, ok, cyc);
    n_vec++;
    if (!ok) begin
      n_miss++; $display("FAIL write_timeout: got no response want response");
    end else begin
      e = exp_q.pop_front();
      if (bus2.resp_valid !== 2'(1 << e.idx) || bus2.resp_data !== e.data) begin
        n_miss++;
        $display("FAIL write_resp: got %b/%h want %b/%h", bus2.resp_valid, bus2.resp_data, 2'(1 << e.idx), e.data);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    ds_stall = 5;
    tick(); tick();
    bus2.resp_ready[0] = 1'b0;
    drive_req(0, 1'b0, 12'h342, 64'hFACE);
    exp_q.push_back('{0, ds_model(1'b0, 12'h342, 64'h0)});
    #1;
    n_vec++;
    if (bus2.req_ready !== 2'b01) begin
      n_miss++; $display("FAIL bp_grant: got %b want 01", bus2.req_ready);
    end
    for (int s = 0; s < 5; s++) begin
      tick();
      if (s == 0) bus2.req_valid = '0;
      #1;
      n_vec++;
      if ({bus2.pcr_req_valid, bus2.pcr_req_ready, bus2.pcr_req_rw, busy2, bus2.pcr_req_addr} !== {4'b1001, 12'h342}) begin
        n_miss++;
        $display("FAIL bp_issue_hold: got %h want %h",
                 {bus2.pcr_req_valid, bus2.pcr_req_ready, bus2.pcr_req_rw, busy2, bus2.pcr_req_addr}, {4'b1001, 12'h342});
      end
    end
    tick(); #1;
    n_vec++;
    if ({bus2.pcr_req_valid, bus2.pcr_req_ready} !== 2'b11) begin
      n_miss++; $display("FAIL bp_release: got %b want 11", {bus2.pcr_req_valid, bus2.pcr_req_ready});
    end
    for (int s = 0; s < 3; s++) begin
      tick(); #1;
      n_vec++;
      if ({bus2.resp_valid, bus2.pcr_resp_ready, busy2} !== 4'b0101) begin
        n_miss++; $display("FAIL bp_wait_hold: got %b want 0101", {bus2.resp_valid, bus2.pcr_resp_ready, busy2});
      end
    end
    tick(); bus2.resp_ready[0] = 1'b1; #1;
    e = exp_q.pop_front();
    n_vec++;
    if (bus2.pcr_resp_ready !== 1'b1 || bus2.resp_valid !== 2'(1 << e.idx) || bus2.resp_data !== e.data) begin
      n_miss++;
      $display("FAIL bp_resp: got %b/%b/%h want 1/%b/%h", bus2.pcr_resp_ready, bus2.resp_valid,
               bus2.resp_data, 2'(1 << e.idx), e.data);
    end
    tick(); #1;
    n_vec++;
    if (busy2 !== 1'b0) begin
      n_miss++; $display("FAIL bp_done: got busy=%b want 0", busy2);
    end
    tick();
  endtask

  task automatic test_contention();
    int g; int grants; int cyc; exp_t e;
    reset = 1'b1; tick(); reset = 1'b0;
`ifdef VSCALE_HTIF_ARB_FIXED_PRIO_EN
    grant_q = '{0, 0, 0, 0};
`else
    grant_q = '{0, 1, 0, 1};
`endif
    drive_req(0, 1'b0, 12'h100, 64'h0);
    drive_req(1, 1'b0, 12'h101, 64'h0);
    grants = 0;
    cyc = 0;
    while ((grants < 4 || exp_q.size() > 0) && cyc < 60) begin
      #1;
      if (bus2.req_ready != 2'b00) begin
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 0;
        n_vec++;
        if (bus2.req_ready !== 2'(1 << g)) begin
          n_miss++; $display("FAIL contention_grant%0d: got %b want %b", grants, bus2.req_ready, 2'(1 << g));
        end
        exp_q.push_back('{g, ds_model(1'b0, 12'h100 + 12'(g), 64'h0)});
        grants++;
      end
      if (bus2.resp_valid != 2'b00) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++; $display("FAIL contention_extra_resp: got %b want 00", bus2.resp_valid);
        end else begin
          e = exp_q.pop_front();
          if (bus2.resp_valid !== 2'(1 << e.idx) || bus2.resp_data !== e.data) begin
            n_miss++;
            $display("FAIL contention_resp: got %b/%h want %b/%h", bus2.resp_valid, bus2.resp_data,
                     2'(1 << e.idx), e.data);
          end
        end
      end
      tick();
      cyc++;
      if (grants == 4) bus2.req_valid = '0;
    end
    n_vec++;
    if (grants != 4 || exp_q.size() != 0) begin
      n_miss++; $display("FAIL contention_timeout: got grants=%0d pending=%0d want 4/0", grants, exp_q.size());
      exp_q.delete();
    end
    bus2.req_valid = '0;
  endtask

  task automatic test_reset_in_wait();
    bit ok; int cyc; exp_t e;
    bus2.resp_ready = '0;
    drive_req(0, 1'b0, 12'h7C0, 64'h0);
    tick(); bus2.req_valid = '0; #1;
    wait_resp(10, ok, cyc);
    n_vec++;
    if (!ok || bus2.resp_valid !== 2'b01) begin
      n_miss++; $display("FAIL rst_reach_wait: got %b want 01", bus2.resp_valid);
    end
    tick();
    ds_en = 1'b0;
    bus2.pcr_resp_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    n_vec++;
    if ({bus2.req_ready, bus2.resp_valid, bus2.pcr_req_valid, busy2} !== 6'b0 || bus2.resp_data !== 64'h0) begin
      n_miss++;
      $display("FAIL rst_mid_outputs: got %b/%h want 000000/0",
               {bus2.req_ready, bus2.resp_valid, bus2.pcr_req_valid, busy2}, bus2.resp_data);
    end
    tick();
    bus2.pcr_resp_valid = 1'b1;
    bus2.pcr_resp_data  = 64'h0BAD;
    #1;
    n_vec++;
    if ({bus2.pcr_resp_ready, bus2.resp_valid, busy2} !== 4'b1000) begin
      n_miss++; $display("FAIL rst_stray_absorb: got %b want 1000", {bus2.pcr_resp_ready, bus2.resp_valid, busy2});
    end
    tick();
    bus2.pcr_resp_valid = 1'b0;
    #1;
    n_vec++;
    if ({bus2.resp_valid, busy2} !== 3'b000) begin
      n_miss++; $display("FAIL rst_stray_after: got %b want 000", {bus2.resp_valid, busy2});
    end
    ds_en = 1'b1;
    bus2.resp_ready = '1;
    tick(); tick();
    drive_req(1, 1'b0, 12'h7C1, 64'h0);
    exp_q.push_back('{1, ds_model(1'b0, 12'h7C1, 64'h0)});
    #1;
    n_vec++;
    if (bus2.req_ready !== 2'b10) begin
      n_miss++; $display("FAIL rst_next_grant: got %b want 10", bus2.req_ready);
    end
    tick(); bus2.req_valid = '0; #1;
    wait_resp(10, ok, cyc);
    n_vec++;
    if (!ok) begin
      n_miss++; $display("FAIL rst_next_timeout: got no response want response");
    end else begin
      e = exp_q.pop_front();
      if (bus2.resp_valid !== 2'(1 << e.idx) || bus2.resp_data !== e.data) begin
        n_miss++;
        $display("FAIL rst_next_resp: got %b/%h want %b/%h", bus2.resp_valid, bus2.resp_data, 2'(1 << e.idx), e.data);
      end
    end
    tick();
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp_ready, exp_resp; exp_t e;
    bus3.req_valid = 3'b100;
    bus3.req_addr[2*AW +: AW] = 12'h0A2;
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_ready = (k % 3 == 0) ? 3'b100 : 3'b000;
      exp_resp  = (k % 3 == 2) ? 3'b100 : 3'b000;
      if (exp_ready != 3'b000) exp_q.push_back('{2, 64'h3333});
      n_vec++;
      if ({bus3.req_ready, bus3.resp_valid} !== {exp_ready, exp_resp}) begin
        n_miss++;
        $display("FAIL wrap_cycle%0d: got %b want %b", k, {bus3.req_ready, bus3.resp_valid}, {exp_ready, exp_resp});
      end
      if (exp_resp != 3'b000 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus3.resp_data !== e.data) begin
          n_miss++; $display("FAIL wrap_data%0d: got %h want %h", k, bus3.resp_data, e.data);
        end
      end
      tick();
    end
    exp_q.delete();
    bus3.req_valid = 3'b110;
    #1;
    n_vec++;
    if (bus3.req_ready !== 3'b010) begin
      n_miss++; $display("FAIL wrap_ptr_zero: got %b want 010", bus3.req_ready);
    end
    tick(); bus3.req_valid = '0;
    tick(); #1;
    n_vec++;
    if (bus3.resp_valid !== 3'b010 || bus3.resp_data !== 64'h3333) begin
      n_miss++; $display("FAIL wrap_last_resp: got %b/%h want 010/3333", bus3.resp_valid, bus3.resp_data);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus2.req_valid = '0; bus2.req_rw = '0; bus2.req_addr = '0; bus2.req_data = '0;
    bus2.resp_ready = '1;
    bus3.req_valid = '0; bus3.req_rw = '0; bus3.req_addr = '0; bus3.req_data = '0;
    bus3.resp_ready = '1;
    bus3.pcr_req_ready = 1'b1;
    bus3.pcr_resp_valid = 1'b1;
    bus3.pcr_resp_data = 64'h3333;
    test_reset();
    test_single_read();
    test_write();
    test_backpressure();
    test_contention();
    test_reset_in_wait();
    test_rr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/vscale_htif_pcr_arbiter.md
Name: vscale_htif_pcr_arbiter

Overview:
- Shares the single HTIF PCR request/response channel of the vscale CSR file between N_REQ host-side requesters, e.g. the debug host and a Wishbone-to-PCR bridge.
- Runs one transaction at a time; a transaction is one request plus its response.
- Grants requesters round-robin, registers the winning request, and routes the response back to the winner only.
- Sits between the requesters and the CSR file's htif_pcr_* ports.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 12, CSR address width
DATA_W, 64, HTIF PCR data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester request accepted
req_rw  in  N_REQ  per-requester write flag (1 = write)
req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i in bits [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  flattened write data
resp_valid  out  N_REQ  per-requester response valid
resp_ready  in  N_REQ  per-requester response ready
resp_data  out  DATA_W  response data, shared by all requesters, qualified by resp_valid
pcr_req_valid  out  1  to CSR file
pcr_req_ready  in  1  from CSR file
pcr_req_rw  out  1  to CSR file
pcr_req_addr  out  ADDR_W  to CSR file
pcr_req_data  out  DATA_W  to CSR file
pcr_resp_valid  in  1  from CSR file
pcr_resp_ready  out  1  to CSR file
pcr_resp_data  in  DATA_W  from CSR file
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: FSM=IDLE, rr_ptr=0, grant=0, latched rw/addr/data=0. Outputs: req_ready=0, resp_valid=0, pcr_req_valid=0, busy=0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch winner's rw/addr/data, grant<=winner, go to ISSUE.
  - No valid requester: stay in IDLE.
  - pcr_resp_ready=1 in IDLE; any stray downstream response (e.g. after reset mid-transaction) is consumed and discarded, never routed.
- ISSUE:
  - pcr_req_valid=1, driven from registers only (no combinational path from req_* to pcr_req_*).
  - When pcr_req_ready=1: go to WAIT.
  - req_ready is all 0.
- WAIT:
  - resp_valid[grant]=pcr_resp_valid; resp_data=pcr_resp_data; pcr_resp_ready=resp_ready[grant].
  - All other resp_valid bits are 0.
  - On pcr_resp_valid && resp_ready[grant]: rr_ptr<=(grant+1) mod N_REQ, go to IDLE.
- resp_valid is 0 outside WAIT. resp_data is 0 outside WAIT.
- Latency (0-wait-state downstream): request accepted in cycle T, pcr_req_valid in T+1, response earliest in T+2. Next grant is in the cycle after the response handshake.
- Requester contract: a requester holds req_* stable until req_ready. Dropping req_valid before grant is legal; it simply loses arbitration.
- Simultaneous events:
  - A requester re-asserting req_valid during ISSUE or WAIT waits; it is never accepted until IDLE.
  - If all requesters are valid continuously, each is granted once per N_REQ transactions; no starvation.
- Reset mid-operation (ISSUE or WAIT): returns to IDLE next edge; no resp_valid is produced for the aborted transaction.
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
Macro VSCALE_HTIF_ARB_FIXED_PRIO_EN.
- Defined: arbitration in IDLE is fixed priority, lowest index wins; rr_ptr is not implemented (treated as constant 0).
- Undefined: round-robin as specified above.
- All other behaviour (FSM, routing, latency, reset) is identical in both builds.

Test Plan:
1. Single read: requester 1 reads addr 0x780 (to_host); downstream returns 0x0000_0000_DEAD_BEEF.
   -> req_ready[1] high 1 cycle; pcr_req_addr=0x780, pcr_req_rw=0 one cycle later; resp_valid[1] with resp_data=0xDEADBEEF; resp_valid[0] stays 0.
2. Contention: both requesters valid continuously from reset, 4 transactions.
   -> grant order 0,1,0,1; with VSCALE_HTIF_ARB_FIXED_PRIO_EN defined, order 0,0,0,0.
3. Backpressure: pcr_req_ready low for 5 cycles, then resp_ready[0] low for 3 cycles after pcr_resp_valid.
   -> pcr_req fields stable throughout; FSM stays ISSUE then WAIT; pcr_resp_ready tracks resp_ready[0]; completes after both release.
4. Write: requester 0 writes 0x1234 to addr 0x781.
   -> pcr_req_rw=1, pcr_req_data=0x1234; response routed only to requester 0.
5. Reset in WAIT, then a stray pcr_resp_valid pulse.
   -> after reset all outputs 0, busy=0; stray pulse absorbed with pcr_resp_ready=1 and no resp_valid; next request from requester 1 granted normally with rr_ptr=0.
6. N_REQ=3, only requester 2 valid, 3 back-to-back transactions.
   -> each granted; rr_ptr wraps 2->0 after each completion; no gap beyond the one IDLE cycle.
